// File: rtl/move_input_conditioner.sv
// Turns four raw, bouncy direction buttons into clean one-cycle n/s/e/w move pulses.
// Each button is synchronised and debounced. An arbiter then allows one move per press.
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_e,
  input  logic btn_w,
  output logic n,
  output logic s,
  output logic e,
  output logic w,
  output logic busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere: [3]=n, [2]=s, [1]=e, [0]=w.
  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] stable;
  logic [3:0] winner;
  logic [3:0] pulse;
  logic [0:0] state;

  assign raw = {btn_n, btn_s, btn_e, btn_w};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt;

    // A change is accepted only after it holds for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt       <= '0;
        stable[i] <= 1'b0;
      end else if (sync2[i] == stable[i]) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt       <= '0;
        stable[i] <= sync2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    winner = 4'b0000;
    if (stable[3])      winner = 4'b1000;
    else if (stable[2]) winner = 4'b0100;
    else if (stable[1]) winner = 4'b0010;
    else if (stable[0]) winner = 4'b0001;
  end

  // One pulse per press: HOLD blocks everything until all buttons are released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pulse <= 4'b0000;
      busy  <= 1'b0;
    end else begin
      pulse <= 4'b0000;
      case (state)
        IDLE: begin
          if (|stable) begin
            pulse <= winner;
            state <= HOLD;
            busy  <= 1'b1;
          end
        end
        HOLD: begin
          if (stable == 4'b0000) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign n = pulse[3];
  assign s = pulse[2];
  assign e = pulse[1];
  assign w = pulse[0];

endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed bench for move_input_conditioner with DEBOUNCE_CYCLES = 4.
// Edge numbering: inputs change just after an edge, and the next rising edge is edge 0.
module tb_move_input_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic btn_n, btn_s, btn_e, btn_w;
  logic n, s, e, w, busy;

  int testsRun = 0;
  int testsFailed = 0;

  move_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_n),
    .btn_s (btn_s),
    .btn_e (btn_e),
    .btn_w (btn_w),
    .n     (n),
    .s     (s),
    .e     (e),
    .w     (w),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Observed vector is {n,s,e,w,busy}.
  task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got nsewb=%b, expected %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] buttons);
    {btn_n, btn_s, btn_e, btn_w} = buttons;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step through edges 0..edges-1 and check outputs after each one.
  task automatic runEdges(input string tag, input int edges, input int pulseEdge,
                          input logic [3:0] pulseVec, input int busyEdge,
                          input logic busyBefore, input logic busyAfter);
    logic [3:0] expPulse;
    logic       expBusy;
    for (int k = 0; k < edges; k++) begin
      tick();
      expPulse = (k == pulseEdge) ? pulseVec : 4'b0000;
      expBusy  = (busyEdge >= 0 && k >= busyEdge) ? busyAfter : busyBefore;
      checkOutput($sformatf("%s_edge%0d", tag, k), {n, s, e, w, busy}, {expPulse, expBusy});
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(4'b0000);
    tick();
    tick();
    checkOutput("reset_state", {n, s, e, w, busy}, 5'b00000);
    reset = 1'b0;

    // Single north press: pulse at edge 6 only, busy from edge 6.
    applyStimulus(4'b1000);
    runEdges("n_press", 9, 6, 4'b1000, 6, 1'b0, 1'b1);
    applyStimulus(4'b0000);
    runEdges("n_release", 8, -1, 4'b0000, 6, 1'b1, 1'b0);

    // East bounce 1,0,1,1,0 never holds long enough to be accepted.
    applyStimulus(4'b0010); tick(); checkOutput("e_bounce0", {n, s, e, w, busy}, 5'b00000);
    applyStimulus(4'b0000); tick(); checkOutput("e_bounce1", {n, s, e, w, busy}, 5'b00000);
    applyStimulus(4'b0010); tick(); checkOutput("e_bounce2", {n, s, e, w, busy}, 5'b00000);
    applyStimulus(4'b0010); tick(); checkOutput("e_bounce3", {n, s, e, w, busy}, 5'b00000);
    applyStimulus(4'b0000); tick(); checkOutput("e_bounce4", {n, s, e, w, busy}, 5'b00000);
    runEdges("e_bounce_settle", 10, -1, 4'b0000, -1, 1'b0, 1'b0);

    // South and west together: only south pulses; west re-press afterwards pulses.
    applyStimulus(4'b0101);
    runEdges("sw_press", 10, 6, 4'b0100, 6, 1'b0, 1'b1);
    applyStimulus(4'b0000);
    runEdges("sw_release", 8, -1, 4'b0000, 6, 1'b1, 1'b0);
    applyStimulus(4'b0001);
    runEdges("w_press", 9, 6, 4'b0001, 6, 1'b0, 1'b1);
    applyStimulus(4'b0000);
    runEdges("w_release", 8, -1, 4'b0000, 6, 1'b1, 1'b0);

    // North held, east added mid-hold, north released: no east pulse until re-press.
    applyStimulus(4'b1000);
    runEdges("n_hold", 8, 6, 4'b1000, 6, 1'b0, 1'b1);
    applyStimulus(4'b1010);
    runEdges("ne_hold", 8, -1, 4'b0000, -1, 1'b1, 1'b1);
    applyStimulus(4'b0010);
    runEdges("e_only_hold", 10, -1, 4'b0000, -1, 1'b1, 1'b1);
    applyStimulus(4'b0000);
    runEdges("e_release", 8, -1, 4'b0000, 6, 1'b1, 1'b0);
    applyStimulus(4'b0010);
    runEdges("e_press", 9, 6, 4'b0010, 6, 1'b0, 1'b1);
    applyStimulus(4'b0000);
    runEdges("e_release2", 8, -1, 4'b0000, 6, 1'b1, 1'b0);

    // Reset during an active pulse, north held through reset.
    applyStimulus(4'b1000);
    runEdges("n_pre_reset", 7, 6, 4'b1000, 6, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_drop", {n, s, e, w, busy}, 5'b00000);
    tick();
    tick();
    checkOutput("held_in_reset", {n, s, e, w, busy}, 5'b00000);
    reset = 1'b0;
    runEdges("n_after_reset", 9, 6, 4'b1000, 6, 1'b0, 1'b1);
    applyStimulus(4'b0000);
    runEdges("n_after_reset_release", 8, -1, 4'b0000, 6, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
